// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO constants and address-width helpers
package fifo_pkg;

    // Bit positions of the sticky error flags when packed into a status word
    localparam int ERR_OVERFLOW_BIT  = 0;
    localparam int ERR_UNDERFLOW_BIT = 1;
    localparam int ERR_BITS          = 2;

    // Ceiling log2 for elaboration-time sizing
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Storage address width for a given depth; never narrower than one bit
    function automatic int addr_width(input int depth);
        return (depth < 2) ? 1 : clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - WIDTH x DEPTH storage, synchronous write, asynchronous read
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clock,
    input  logic             write_en,
    input  logic [AW-1:0]    write_addr,
    input  logic [WIDTH-1:0] write_data,
    input  logic [AW-1:0]    read_addr,
    output logic [WIDTH-1:0] read_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; the top never exposes an unwritten entry
    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    assign read_data = mem[read_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with flags, errors, flush, FWFT
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                                clock,
    input  logic                                resetn,
    input  logic                                flush,
    input  logic                                clear_err,
    input  logic                                write_enb,
    input  logic [WIDTH-1:0]                    data_in,
    input  logic                                read_enb,
    output logic [WIDTH-1:0]                    data_out,
    output logic                                data_valid,
    output logic                                full,
    output logic                                almost_full,
    output logic                                empty,
    output logic                                almost_empty,
    output logic [fifo_pkg::addr_width(DEPTH):0] count,
    output logic                                overflow,
    output logic                                underflow
);

    localparam int          AW     = addr_width(DEPTH);
    localparam logic [AW:0] AF_LVL = AF_THRESH[AW:0];
    localparam logic [AW:0] AE_LVL = AE_THRESH[AW:0];

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_accept;
    logic             rd_accept;
    logic             ovf_set;
    logic             udf_set;
    logic [WIDTH-1:0] ram_rdata;

    // Flags come only from registered pointers; the extra MSB tells full from empty
    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count        = wr_ptr - rd_ptr;
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    // Flush wins over both requests; rejected requests outside flush raise errors
    assign wr_accept = write_enb & ~full  & ~flush;
    assign rd_accept = read_enb  & ~empty & ~flush;
    assign ovf_set   = write_enb & full   & ~flush;
    assign udf_set   = read_enb  & empty  & ~flush;

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clock      (clock),
        .write_en   (wr_accept),
        .write_addr (wr_ptr[AW-1:0]),
        .write_data (data_in),
        .read_addr  (rd_ptr[AW-1:0]),
        .read_data  (ram_rdata)
    );

    // Pointer advance, with flush returning both to the origin
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
            if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Sticky error flags; a new error in the same cycle as clear_err is kept
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set)        overflow  <= 1'b1;
            else if (clear_err) overflow  <= 1'b0;
            if (udf_set)        underflow <= 1'b1;
            else if (clear_err) underflow <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word shown directly; masked while empty so stale storage never leaks
            assign data_out   = empty ? '0 : ram_rdata;
            assign data_valid = ~empty;
        end else begin : g_registered
            // One-cycle read: capture the head on an accepted read, otherwise hold
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    data_out   <= '0;
                    data_valid <= 1'b0;
                end else begin
                    data_valid <= rd_accept;
                    if (rd_accept) data_out <= ram_rdata;
                end
            end
        end
    endgenerate

endmodule
